// File: rtl/ct_ciu_regs_req_ctrl.sv
// ct_ciu_regs_req_ctrl: round-robin initiator for the CIU cluster-register bus.
//   forever_cpuclk/cpurst_b : clock, async active-low reset
//   core_req_*              : per-core CSR requests, core_req_rdy one-hot accept pulse
//   kid_csr_value           : combinational read value of every kid
//   regs_*                  : shared kid register bus, driven only in the access cycle
//   core_rsp_*              : one-cycle response pulse with read data / kid-range error
module ct_ciu_regs_req_ctrl #(
  parameter int CORE_NUM = 4,
  parameter int KID_NUM  = 4
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst_b,
  input  logic [CORE_NUM-1:0]    core_req_vld,
  input  logic [CORE_NUM-1:0]    core_req_wen,
  input  logic [2*CORE_NUM-1:0]  core_req_kid,
  input  logic [4*CORE_NUM-1:0]  core_req_idx,
  input  logic [64*CORE_NUM-1:0] core_req_wdata,
  input  logic [4*CORE_NUM-1:0]  core_req_l2of_mask,
  output logic [CORE_NUM-1:0]    core_req_rdy,
  input  logic [64*KID_NUM-1:0]  kid_csr_value,
  output logic [KID_NUM-1:0]     regs_sel_final,
  output logic [3:0]             regs_idx,
  output logic                   regs_wen,
  output logic [63:0]            regs_wdata_final,
  output logic [3:0]             regs_l2of_wen,
  output logic [CORE_NUM-1:0]    core_rsp_vld,
  output logic [63:0]            core_rsp_rdata,
  output logic                   core_rsp_err
);
  typedef enum logic [1:0] {IDLE, ACC, RSP} state_e;
  state_e      state_q, state_d;
  logic [1:0]  rr_q, rr_d, gnt_q, gnt, c, kid_q;
  logic        found, wen_q, kid_ok, err_q;
  logic [3:0]  idx_q, mask_q;
  logic [63:0] wdata_q, rdata_q, rd_val;
  // Round-robin search starting at rr_q, wrapping modulo CORE_NUM.
  always_comb begin
    found = 1'b0;
    gnt = '0;
    c = '0;
    for (int k = 0; k < CORE_NUM; k++) begin
      c = 2'((int'(rr_q) + k) % CORE_NUM);
      if (!found && core_req_vld[c]) begin
        found = 1'b1;
        gnt = c;
      end
    end
    rr_d = 2'((int'(gnt) + 1) % CORE_NUM);
    state_d = (state_q == IDLE) ? (found ? ACC : IDLE) : (state_q == ACC) ? RSP : IDLE;
  end
  assign kid_ok = int'(kid_q) < KID_NUM;
  always_comb begin
    rd_val = '0;
    regs_sel_final = '0;
    for (int k = 0; k < KID_NUM; k++) begin
      if (kid_q == 2'(k)) rd_val = kid_csr_value[64*k +: 64];
      regs_sel_final[k] = (state_q == ACC) && (kid_q == 2'(k));
    end
    core_req_rdy = '0;
    core_rsp_vld = '0;
    for (int k = 0; k < CORE_NUM; k++) begin
      // Gated by reset so a request held during reset is not shown as accepted.
      core_req_rdy[k] = cpurst_b && (state_q == IDLE) && found && (gnt == 2'(k));
      core_rsp_vld[k] = (state_q == RSP) && (gnt_q == 2'(k));
    end
  end
  assign regs_idx         = idx_q;
  assign regs_wdata_final = wdata_q;
  assign regs_wen         = (state_q == ACC) && wen_q && kid_ok;
  assign regs_l2of_wen    = (regs_wen && idx_q == 4'hc) ? mask_q : '0;
  assign core_rsp_rdata   = (state_q == RSP) ? rdata_q : '0;
  assign core_rsp_err     = (state_q == RSP) && err_q;
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      wen_q   <= 1'b0;
      kid_q   <= '0;
      idx_q   <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found) begin
        rr_q    <= rr_d;
        gnt_q   <= gnt;
        wen_q   <= core_req_wen[gnt];
        kid_q   <= core_req_kid[{gnt, 1'b0} +: 2];
        idx_q   <= core_req_idx[{gnt, 2'b0} +: 4];
        mask_q  <= core_req_l2of_mask[{gnt, 2'b0} +: 4];
        wdata_q <= core_req_wdata[{gnt, 6'b0} +: 64];
      end
      // Sampled on the same edge the kid applies a write, so writes return the old value.
      if (state_q == ACC) begin
        rdata_q <= kid_ok ? rd_val : '0;
        err_q   <= ~kid_ok;
      end
    end
  end
endmodule
